// File: rtl/exception_pkg.sv
// Shared types and default vector addresses for the exception sequencer.
package exception_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEC_RD = 2'd1,
        VEC_LD = 2'd2,
        RET    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        OPC  = 2'b01,
        OVF  = 2'b10,
        IRQ  = 2'b11
    } cause_e;

    localparam logic [31:0] VEC_OPC_DEF = 32'd254;
    localparam logic [31:0] VEC_OVF_DEF = 32'd255;
    localparam logic [31:0] VEC_IRQ_DEF = 32'd253;

endpackage

// File: rtl/exception_controller.sv
// Takes over the multicycle datapath on exceptions/interrupts: saves the
// return PC and cause, fetches the handler vector byte, loads the PC, and
// restores the saved PC on eret.
module exception_controller
    import exception_pkg::*;
#(
    parameter logic [31:0] VEC_OPC = VEC_OPC_DEF,
    parameter logic [31:0] VEC_OVF = VEC_OVF_DEF,
    parameter logic [31:0] VEC_IRQ = VEC_IRQ_DEF,
    parameter int          MEM_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_opcode,
    input  logic        ex_overflow,
    input  logic        irq,
    input  logic        instr_boundary,
    input  logic        eret,
    input  logic [31:0] pc,
    input  logic [31:0] mem_data,
    output logic        uc_hold,
    output logic        addr_sel_ex,
    output logic [31:0] vec_addr,
    output logic        pc_write_ex,
    output logic [31:0] pc_ex,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic        ie
);

    localparam int CW = $clog2(MEM_LAT + 1);

    state_e          state_q, state_d;
    cause_e          cause_q;
    cause_e          take_cause;
    logic            take;
    logic [31:0]     take_epc;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      vec_q;
    logic            unused_mem_hi;

    // Only the low byte of memory data carries the vector.
    assign unused_mem_hi = ^mem_data[31:8];

    // Prioritised trigger selection; sync exceptions ignore ie, and
    // pc has already been advanced past the faulting instruction.
    always_comb begin
        take       = 1'b1;
        take_cause = NONE;
        take_epc   = pc;
        if (ex_opcode) begin
            take_cause = OPC;
            take_epc   = pc - 32'd4;
        end else if (ex_overflow) begin
            take_cause = OVF;
            take_epc   = pc - 32'd4;
        end else if (irq && ie && instr_boundary) begin
            take_cause = IRQ;
        end else begin
            take = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a trigger wins over a same-cycle eret.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take)      state_d = VEC_RD;
                else if (eret) state_d = RET;
            end
            VEC_RD: if (cnt_q == CW'(1)) state_d = VEC_LD;
            VEC_LD: state_d = IDLE;
            RET:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Saved context, wait counter and fetched vector byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            epc     <= '0;
            cause_q <= NONE;
            ie      <= 1'b1;
            cnt_q   <= '0;
            vec_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take) begin
                        epc     <= take_epc;
                        cause_q <= take_cause;
                        ie      <= 1'b0;
                        cnt_q   <= CW'(MEM_LAT);
                    end
                end
                VEC_RD: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) vec_q <= mem_data[7:0];
                end
                RET: begin
                    ie      <= 1'b1;
                    cause_q <= NONE;
                end
                default: ;
            endcase
        end
    end

    assign cause = cause_q;

    // Vector address follows the recorded cause.
    always_comb begin
        case (cause_q)
            OPC:     vec_addr = VEC_OPC;
            OVF:     vec_addr = VEC_OVF;
            IRQ:     vec_addr = VEC_IRQ;
            default: vec_addr = '0;
        endcase
    end

    // Moore outputs decoded from state.
    always_comb begin
        uc_hold     = 1'b0;
        addr_sel_ex = 1'b0;
        pc_write_ex = 1'b0;
        pc_ex       = '0;
        case (state_q)
            VEC_RD: begin
                uc_hold     = 1'b1;
                addr_sel_ex = 1'b1;
            end
            VEC_LD: begin
                uc_hold     = 1'b1;
                pc_write_ex = 1'b1;
                pc_ex       = {24'b0, vec_q};
            end
            RET: begin
                uc_hold     = 1'b1;
                pc_write_ex = 1'b1;
                pc_ex       = epc;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exception_controller.sv
// Directed bench for exception_controller (default parameters, MEM_LAT=1).
module tb_exception_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_opcode, ex_overflow, irq, instr_boundary, eret;
    logic [31:0] pc, mem_data;
    logic        uc_hold, addr_sel_ex, pc_write_ex, ie;
    logic [31:0] vec_addr, pc_ex, epc;
    logic [1:0]  cause;

    int checks = 0;
    int failures = 0;

    exception_controller dut (
        .clock(clock), .reset(reset),
        .ex_opcode(ex_opcode), .ex_overflow(ex_overflow), .irq(irq),
        .instr_boundary(instr_boundary), .eret(eret), .pc(pc),
        .mem_data(mem_data), .uc_hold(uc_hold), .addr_sel_ex(addr_sel_ex),
        .vec_addr(vec_addr), .pc_write_ex(pc_write_ex), .pc_ex(pc_ex),
        .epc(epc), .cause(cause), .ie(ie)
    );

    always #5 clock = ~clock;

    // Memory model: vector bytes with junk in the upper bits, only driven
    // while the controller owns the address mux.
    assign mem_data = !addr_sel_ex         ? 32'hDEAD_BEEF :
                      (vec_addr == 32'd254) ? 32'hAB00_0040 :
                      (vec_addr == 32'd255) ? 32'hCD00_0060 :
                      (vec_addr == 32'd253) ? 32'hEF00_0080 : 32'h0000_0011;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Runs eret from IDLE and checks the restore pulse and ie re-enable.
    task automatic do_eret(input string tag, input logic [31:0] exp_pc);
        eret = 1'b1;
        step();
        eret = 1'b0;
        chk({tag, "_ret_pcw"}, 32'(pc_write_ex), 32'd1);
        chk({tag, "_ret_pcex"}, pc_ex, exp_pc);
        chk({tag, "_ret_hold"}, 32'(uc_hold), 32'd1);
        step();
        chk({tag, "_ret_ie"}, 32'(ie), 32'd1);
        chk({tag, "_ret_cause"}, 32'(cause), 32'd0);
        chk({tag, "_ret_idle"}, {30'd0, uc_hold, pc_write_ex}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        {ex_opcode, ex_overflow, irq, instr_boundary, eret} = '0;
        pc = '0;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_ie", 32'(ie), 32'd1);
        chk("rst_cause", 32'(cause), 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_outs", {29'd0, uc_hold, pc_write_ex, addr_sel_ex}, 32'd0);
        chk("rst_vec", vec_addr, 32'd0);

        // Invalid opcode at pc=0x10.
        instr_boundary = 1'b1;
        pc = 32'h10; ex_opcode = 1'b1;
        step();
        ex_opcode = 1'b0;
        chk("opc_epc", epc, 32'h0C);
        chk("opc_cause", 32'(cause), 32'd1);
        chk("opc_ie", 32'(ie), 32'd0);
        chk("opc_rd", {29'd0, uc_hold, addr_sel_ex, pc_write_ex}, 32'b110);
        chk("opc_vaddr", vec_addr, 32'd254);
        step();
        chk("opc_ld", {29'd0, uc_hold, addr_sel_ex, pc_write_ex}, 32'b101);
        chk("opc_pcex", pc_ex, 32'h40);
        step();
        chk("opc_done", {29'd0, uc_hold, addr_sel_ex, pc_write_ex}, 32'b000);
        do_eret("opc", 32'h0C);

        // Overflow beats a simultaneous enabled irq.
        pc = 32'h24; ex_overflow = 1'b1; irq = 1'b1;
        step();
        ex_overflow = 1'b0; irq = 1'b0;
        chk("ovf_cause", 32'(cause), 32'd2);
        chk("ovf_epc", epc, 32'h20);
        chk("ovf_vaddr", vec_addr, 32'd255);
        step();
        chk("ovf_pcex", pc_ex, 32'h60);
        step();
        do_eret("ovf", 32'h20);

        // External interrupt at boundary; level held through handling.
        pc = 32'h20; irq = 1'b1;
        step();
        chk("irq_cause", 32'(cause), 32'd3);
        chk("irq_epc", epc, 32'h20);
        chk("irq_ie", 32'(ie), 32'd0);
        chk("irq_vaddr", vec_addr, 32'd253);
        pc = 32'h44;
        step();
        chk("irq_pcw", 32'(pc_write_ex), 32'd1);
        chk("irq_pcex", pc_ex, 32'h80);
        step(); step(); step();
        chk("irq_masked_hold", 32'(uc_hold), 32'd0);
        chk("irq_masked_epc", epc, 32'h20);
        irq = 1'b0;
        do_eret("irq", 32'h20);

        // irq away from an instruction boundary is not taken.
        irq = 1'b1; instr_boundary = 1'b0;
        step(); step(); step();
        chk("nobnd_hold", 32'(uc_hold), 32'd0);
        chk("nobnd_cause", 32'(cause), 32'd0);
        irq = 1'b0; instr_boundary = 1'b1;

        // Trigger and eret together: trigger wins; pc=0 wraps.
        pc = 32'h0; ex_opcode = 1'b1; eret = 1'b1;
        step();
        ex_opcode = 1'b0; eret = 1'b0;
        chk("both_sel", 32'(addr_sel_ex), 32'd1);
        chk("wrap_epc", epc, 32'hFFFF_FFFC);
        step(); step();
        do_eret("wrap", 32'hFFFF_FFFC);

        // Reset in the middle of a vector read.
        pc = 32'h10; ex_opcode = 1'b1;
        step();
        ex_opcode = 1'b0;
        chk("mid_rd", 32'(addr_sel_ex), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_outs", {29'd0, uc_hold, addr_sel_ex, pc_write_ex}, 32'd0);
        chk("mid_rst_epc", epc, 32'd0);
        chk("mid_rst_ie", 32'(ie), 32'd1);
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_pcw", 32'(pc_write_ex), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
